cic_dec_ctrl: RTL and testbench

- Sequencer in front of the CIC decimator. It owns the CIC's decimation factor, valid gating and reset, and performs safe run-time factor changes: drain, clear, load factor, warm-up.
- It also masks CIC warm-up outputs and latches sticky overflow/underflow status for the host.
- It sits between the sample source, the host configuration interface and the CIC instance.

---
 rtl/cic_ctrl_pkg.sv | 24 ++
 rtl/cic_ctrl_timer.sv | 31 +++
 rtl/cic_dec_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cic_dec_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC decimator sequencer: state encoding,
// factor geometry and the legal-factor check.
package cic_ctrl_pkg;

    localparam int MAX_DEC_FACTOR = 16;
    localparam int DEC_WIDTH      = $clog2(MAX_DEC_FACTOR);
    localparam int TIMER_W        = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_e;

    // A factor is usable only if it is a nonzero power of two no larger than the CIC supports.
    function automatic logic is_legal_dec(input logic [DEC_WIDTH:0] dec);
        logic [DEC_WIDTH:0] dec_m1_s;
        logic [DEC_WIDTH:0] max_s;
        max_s    = (DEC_WIDTH+1)'(MAX_DEC_FACTOR);
        dec_m1_s = dec - {{DEC_WIDTH{1'b0}}, 1'b1};
        return (dec != '0) && ((dec & dec_m1_s) == '0) && (dec <= max_s);
    endfunction

endpackage

// File: rtl/cic_ctrl_timer.sv
// Loadable down-counter with a terminal flag; the sequencer reuses it for
// both the drain wait and the CIC clear pulse.
module cic_ctrl_timer
    import cic_ctrl_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority, then decrement until zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign done = (cnt_r == '0);

endmodule

// File: rtl/cic_dec_ctrl.sv
// Sequencer in front of the CIC decimator: safe run-time factor change, warm-up
// masking and sticky status. Optional error counters under CIC_CTRL_ERR_CNT_EN.
module cic_dec_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DEFAULT_DEC    = 2,
    parameter int FLUSH_CYCLES   = 10,
    parameter int CLR_CYCLES     = 2,
    parameter int WARMUP_OUTPUTS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    input  logic [DEC_WIDTH:0]    cfg_dec,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    output logic                  busy,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  cic_valid_in,
    output logic [DATA_WIDTH-1:0] cic_in,
    output logic [DEC_WIDTH:0]    cic_dec_factor,
    output logic                  cic_rst_n,
    input  logic [DATA_WIDTH-1:0] cic_out,
    input  logic                  cic_valid_out,
    input  logic                  cic_overflow,
    input  logic                  cic_underflow,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  sticky_ovf,
    output logic                  sticky_unf,
    input  logic                  sticky_clr
`ifdef CIC_CTRL_ERR_CNT_EN
   ,output logic [15:0]           ovf_cnt,
    output logic [15:0]           unf_cnt
`endif
);

    localparam int WARM_W = (WARMUP_OUTPUTS < 1) ? 1 : $clog2(WARMUP_OUTPUTS + 1);
    localparam logic [DEC_WIDTH:0]  DEFAULT_DEC_V = (DEC_WIDTH+1)'(DEFAULT_DEC);
    localparam logic [WARM_W-1:0]   WARM_INIT     = WARM_W'(WARMUP_OUTPUTS);
    localparam logic [TIMER_W-1:0]  FLUSH_LOAD    = TIMER_W'(FLUSH_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  CLR_LOAD      = TIMER_W'(CLR_CYCLES - 1);

    ctrl_state_e          state_r;
    logic [DEC_WIDTH:0]   pending_r;
    logic [DEC_WIDTH:0]   dec_r;
    logic                 cic_rst_n_r;
    logic [WARM_W-1:0]    warm_r;
    logic                 sticky_ovf_r;
    logic                 sticky_unf_r;

    logic                 in_run_s;
    logic                 cfg_legal_s;
    logic                 cfg_accept_s;
    logic                 timer_load_s;
    logic [TIMER_W-1:0]   timer_val_s;
    logic                 timer_en_s;
    logic                 timer_done_s;

    assign in_run_s     = (state_r == RUN);
    assign cfg_legal_s  = is_legal_dec(cfg_dec);
    assign cfg_accept_s = in_run_s && cfg_valid && cfg_legal_s;

    assign cfg_ready      = in_run_s && cfg_valid;
    assign cfg_err        = in_run_s && cfg_valid && !cfg_legal_s;
    assign busy           = !in_run_s;
    assign s_ready        = in_run_s;
    assign cic_valid_in   = s_valid && in_run_s;
    assign cic_in         = s_data;
    assign cic_dec_factor = dec_r;
    assign cic_rst_n      = cic_rst_n_r;
    assign m_valid        = cic_valid_out && (warm_r == '0);
    assign m_data         = cic_out;
    assign sticky_ovf     = sticky_ovf_r;
    assign sticky_unf     = sticky_unf_r;

    cic_ctrl_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .en       (timer_en_s),
        .done     (timer_done_s)
    );

    // Timer control: arm on DRAIN and CLEAR entry, count down while waiting.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = '0;
        timer_en_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (cfg_accept_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = FLUSH_LOAD;
                end else begin
                    timer_en_s = 1'b0;
                end
            end
            DRAIN: begin
                if (timer_done_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = CLR_LOAD;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            CLEAR: begin
                timer_en_s = 1'b1;
            end
            default: begin
                timer_en_s = 1'b0;
            end
        endcase
    end

    // Reconfiguration FSM with registered CIC reset, factor and warm-up count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            pending_r   <= DEFAULT_DEC_V;
            dec_r       <= DEFAULT_DEC_V;
            cic_rst_n_r <= 1'b0;
            warm_r      <= WARM_INIT;
        end else begin
            case (state_r)
                RUN: begin
                    cic_rst_n_r <= 1'b1;
                    if (cfg_accept_s) begin
                        pending_r <= cfg_dec;
                        state_r   <= DRAIN;
                    end
                    if (cic_valid_out && (warm_r != '0)) begin
                        warm_r <= warm_r - WARM_W'(1);
                    end
                end
                DRAIN: begin
                    if (timer_done_s) begin
                        state_r     <= CLEAR;
                        cic_rst_n_r <= 1'b0;
                        dec_r       <= pending_r;
                        warm_r      <= WARM_INIT;
                    end
                end
                CLEAR: begin
                    if (timer_done_s) begin
                        state_r     <= RUN;
                        cic_rst_n_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= RUN;
                    cic_rst_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Sticky status: CIC flags during its own clear are ignored; a new flag beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_r <= 1'b0;
            sticky_unf_r <= 1'b0;
        end else begin
            if (cic_overflow && (state_r != CLEAR)) begin
                sticky_ovf_r <= 1'b1;
            end else if (sticky_clr) begin
                sticky_ovf_r <= 1'b0;
            end
            if (cic_underflow && (state_r != CLEAR)) begin
                sticky_unf_r <= 1'b1;
            end else if (sticky_clr) begin
                sticky_unf_r <= 1'b0;
            end
        end
    end

`ifdef CIC_CTRL_ERR_CNT_EN
    logic [15:0] ovf_cnt_r;
    logic [15:0] unf_cnt_r;

    // Saturating counts of flagged cycles, cleared together with the sticky bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= 16'h0000;
            unf_cnt_r <= 16'h0000;
        end else begin
            if (sticky_clr) begin
                ovf_cnt_r <= 16'h0000;
            end else if (cic_overflow && (ovf_cnt_r != 16'hFFFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'h0001;
            end
            if (sticky_clr) begin
                unf_cnt_r <= 16'h0000;
            end else if (cic_underflow && (unf_cnt_r != 16'hFFFF)) begin
                unf_cnt_r <= unf_cnt_r + 16'h0001;
            end
        end
    end

    assign ovf_cnt = ovf_cnt_r;
    assign unf_cnt = unf_cnt_r;
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: a simple CIC stand-in, a cycle-level
// expectation model and directed reconfiguration/status scenarios.
module tb_cic_dec_ctrl;
    import cic_ctrl_pkg::*;

    localparam int DW    = 16;
    localparam int DEF   = 2;
    localparam int FLUSH = 10;
    localparam int CLR   = 2;
    localparam int WARM  = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic [DEC_WIDTH:0]   cfg_dec = '0;
    logic                 cfg_ready, cfg_err, busy;
    logic                 s_valid = 1'b0;
    logic [DW-1:0]        s_data = '0;
    logic                 s_ready, cic_valid_in;
    logic [DW-1:0]        cic_in;
    logic [DEC_WIDTH:0]   cic_dec_factor;
    logic                 cic_rst_n;
    logic [DW-1:0]        cic_out = '0;
    logic                 cic_valid_out = 1'b0;
    logic                 cic_overflow = 1'b0;
    logic                 cic_underflow = 1'b0;
    logic                 m_valid;
    logic [DW-1:0]        m_data;
    logic                 sticky_ovf, sticky_unf;
    logic                 sticky_clr = 1'b0;
`ifdef CIC_CTRL_ERR_CNT_EN
    logic [15:0]          ovf_cnt, unf_cnt;
`endif

    cic_dec_ctrl #(
        .DATA_WIDTH(DW), .DEFAULT_DEC(DEF), .FLUSH_CYCLES(FLUSH),
        .CLR_CYCLES(CLR), .WARMUP_OUTPUTS(WARM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_dec(cfg_dec),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cic_valid_in(cic_valid_in), .cic_in(cic_in), .cic_dec_factor(cic_dec_factor),
        .cic_rst_n(cic_rst_n), .cic_out(cic_out), .cic_valid_out(cic_valid_out),
        .cic_overflow(cic_overflow), .cic_underflow(cic_underflow),
        .m_valid(m_valid), .m_data(m_data),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .sticky_clr(sticky_clr)
`ifdef CIC_CTRL_ERR_CNT_EN
       ,.ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic bit legal(input logic [DEC_WIDTH:0] d);
        return d inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
    endfunction

    // CIC stand-in: one output per 'factor' accepted samples, output equals input.
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (!cic_rst_n) begin
            stub_cnt      <= 0;
            cic_valid_out <= 1'b0;
        end else if (cic_valid_in) begin
            if (stub_cnt + 1 >= int'(cic_dec_factor)) begin
                stub_cnt      <= 0;
                cic_valid_out <= 1'b1;
                cic_out       <= cic_in;
            end else begin
                stub_cnt      <= stub_cnt + 1;
                cic_valid_out <= 1'b0;
            end
        end else begin
            cic_valid_out <= 1'b0;
        end
    end

    // Model: cycles of reconfiguration left, current/pending factor, warm-ups left.
    int                 md_busy_left = 0;
    int                 md_warm = WARM;
    logic [DEC_WIDTH:0] md_fac = DEF;
    logic [DEC_WIDTH:0] md_pend = DEF;
    logic               md_crst = 1'b0;
    logic               md_ovf = 1'b0;
    logic               md_unf = 1'b0;

    int n_busy = 0, n_srlow = 0, n_crstlow = 0, n_cfgrdy = 0, n_cfgerr = 0;
    int n_masked = 0, n_mv = 0, last_gap = 0, acc = 0;
    logic [DW-1:0] last_mdata = '0;

    always @(negedge clk) begin
        bit e_busy;
        bit in_clear;
        if (!rst_n) begin
            md_busy_left = 0; md_warm = WARM; md_fac = DEF; md_pend = DEF;
            md_crst = 1'b0; md_ovf = 1'b0; md_unf = 1'b0;
        end
        e_busy = (md_busy_left > 0);
        chk("busy", busy, e_busy);
        chk("s_ready", s_ready, !e_busy);
        chk("cfg_ready", cfg_ready, !e_busy && cfg_valid);
        chk("cfg_err", cfg_err, !e_busy && cfg_valid && !legal(cfg_dec));
        chk("cic_valid_in", cic_valid_in, s_valid && !e_busy);
        chk("cic_in", cic_in, s_data);
        chk("cic_dec_factor", cic_dec_factor, md_fac);
        chk("cic_rst_n", cic_rst_n, md_crst);
        chk("m_valid", m_valid, cic_valid_out && (md_warm == 0));
        chk("m_data", m_data, cic_out);
        chk("sticky_ovf", sticky_ovf, md_ovf);
        chk("sticky_unf", sticky_unf, md_unf);

        if (busy) n_busy++;
        if (!s_ready) n_srlow++;
        if (!cic_rst_n && rst_n) n_crstlow++;
        if (cfg_ready) n_cfgrdy++;
        if (cfg_err) n_cfgerr++;
        if (cic_valid_out && !m_valid) n_masked++;
        if (m_valid) begin
            last_gap = acc; acc = 0; last_mdata = m_data; n_mv++;
        end
        if (cic_valid_in) acc++;

        if (rst_n) begin
            in_clear = (md_busy_left > 0) && (md_busy_left <= CLR);
            if (cic_overflow && !in_clear) md_ovf = 1'b1;
            else if (sticky_clr) md_ovf = 1'b0;
            if (cic_underflow && !in_clear) md_unf = 1'b1;
            else if (sticky_clr) md_unf = 1'b0;
            if (md_busy_left == 0) begin
                if (cfg_valid && legal(cfg_dec)) begin
                    md_pend = cfg_dec;
                    md_busy_left = FLUSH + CLR;
                end
                if (cic_valid_out && md_warm > 0) md_warm--;
                md_crst = 1'b1;
            end else begin
                md_busy_left--;
                if (md_busy_left == CLR) begin
                    md_fac = md_pend; md_warm = WARM; md_crst = 1'b0;
                end else if (md_busy_left == 0) begin
                    md_crst = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, sr0, cr0, rd0, er0, mk0, mv0, waited;
        bit got;
        s_valid = 1'b1;
        s_data  = 16'h4000;

        // Reset values while rst_n is held low.
        tick(3);
        chk("rst_factor", cic_dec_factor, 5'd2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cic_rst_n", cic_rst_n, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b0);

        // Release: first CIC output masked, then one every 2 samples.
        rst_n = 1'b1;
        mk0 = n_masked; mv0 = n_mv;
        tick(24);
        @(negedge clk);
        chk("warmup_masked", n_masked - mk0, 1);
        chk("rst_mv_count", n_mv - mv0, 10);
        chk("dec2_gap", last_gap, 2);
        chk("dec2_data", last_mdata, 16'h4000);

        // Legal change to 8 while streaming.
        b0 = n_busy; sr0 = n_srlow; cr0 = n_crstlow; rd0 = n_cfgrdy; mk0 = n_masked;
        @(posedge clk); #1 cfg_valid = 1'b1; cfg_dec = 5'd8;
        @(posedge clk); #1 cfg_valid = 1'b0;
        tick(60);
        @(negedge clk);
        chk("dec8_ready_pulses", n_cfgrdy - rd0, 1);
        chk("dec8_busy_cycles", n_busy - b0, 12);
        chk("dec8_sready_low", n_srlow - sr0, 12);
        chk("dec8_cicrst_low", n_crstlow - cr0, 2);
        chk("dec8_factor", cic_dec_factor, 5'd8);
        chk("dec8_masked", n_masked - mk0, 1);
        chk("dec8_gap", last_gap, 8);
        chk("dec8_data", last_mdata, 16'h4000);

        // Illegal requests 6 and 0: error pulses only.
        b0 = n_busy; sr0 = n_srlow; rd0 = n_cfgrdy; er0 = n_cfgerr;
        @(posedge clk); #1 cfg_valid = 1'b1; cfg_dec = 5'd6;
        @(posedge clk); #1 cfg_valid = 1'b0;
        tick(3);
        cfg_valid = 1'b1; cfg_dec = 5'd0;
        @(posedge clk); #1 cfg_valid = 1'b0;
        tick(20);
        @(negedge clk);
        chk("illegal_err_pulses", n_cfgerr - er0, 2);
        chk("illegal_ready_pulses", n_cfgrdy - rd0, 2);
        chk("illegal_busy", n_busy - b0, 0);
        chk("illegal_sready_low", n_srlow - sr0, 0);
        chk("illegal_factor", cic_dec_factor, 5'd8);
        chk("illegal_gap", last_gap, 8);

        // Request held through a sequence is accepted on the first RUN cycle.
        b0 = n_busy; cr0 = n_crstlow; rd0 = n_cfgrdy;
        @(posedge clk); #1 cfg_valid = 1'b1; cfg_dec = 5'd2;
        @(posedge clk); #1 cfg_dec = 5'd16;
        waited = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        chk("held_accepted", got, 1'b1);
        chk("held_off_cycles", waited, 12);
        @(posedge clk); #1 cfg_valid = 1'b0;
        tick(80);
        @(negedge clk);
        chk("held_ready_pulses", n_cfgrdy - rd0, 2);
        chk("held_busy_cycles", n_busy - b0, 24);
        chk("held_cicrst_low", n_crstlow - cr0, 4);
        chk("dec16_factor", cic_dec_factor, 5'd16);
        chk("dec16_gap", last_gap, 16);

        // Sticky overflow/underflow behaviour.
        @(posedge clk); #1 cic_overflow = 1'b1;
        tick(3);
        cic_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_set", sticky_ovf, 1'b1);
`ifdef CIC_CTRL_ERR_CNT_EN
        chk("ovf_cnt", ovf_cnt, 16'd3);
`endif
        tick(5);
        chk("ovf_hold", sticky_ovf, 1'b1);
        cic_overflow = 1'b1; sticky_clr = 1'b1;
        tick(1);
        cic_overflow = 1'b0; sticky_clr = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", sticky_ovf, 1'b1);
        @(posedge clk); #1 sticky_clr = 1'b1;
        tick(1);
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", sticky_ovf, 1'b0);
        @(posedge clk); #1 cic_underflow = 1'b1;
        tick(1);
        cic_underflow = 1'b0;
        @(negedge clk);
        chk("unf_set", sticky_unf, 1'b1);
        chk("unf_ovf_quiet", sticky_ovf, 1'b0);
        @(posedge clk); #1 sticky_clr = 1'b1;
        tick(1);
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("unf_cleared", sticky_unf, 1'b0);

        // Reset during CLEAR drops the pending factor at once.
        @(posedge clk); #1 cfg_valid = 1'b1; cfg_dec = 5'd4;
        @(posedge clk); #1 cfg_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cic_rst_n) begin
                got = 1'b1;
                break;
            end
        end
        chk("reached_clear", got, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_factor", cic_dec_factor, 5'd2);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cic_rst_n", cic_rst_n, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        b0 = n_busy;
        tick(30);
        @(negedge clk);
        chk("postrst_factor", cic_dec_factor, 5'd2);
        chk("postrst_busy", n_busy - b0, 0);
        chk("postrst_gap", last_gap, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
